// File: rtl/xorshift_prng_multi.sv
// Multi-lane xorshift PRNG with explicit seeding, zero-seed repair,
// a discarded warm-up run after every seed load, and a valid/ready output.
module xorshift_prng_multi #(
  parameter int unsigned RADIX  = 64,
  parameter int unsigned LANES  = 2,
  parameter int unsigned SH_A   = 21,
  parameter int unsigned SH_B   = 35,
  parameter int unsigned SH_C   = 4,
  parameter int unsigned WARMUP = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   seed_we,
  input  logic [LANES*RADIX-1:0] seed,
  output logic                   rnd_valid,
  input  logic                   rnd_ready,
  output logic [LANES*RADIX-1:0] rnd_out,
  output logic                   seeded
);

  localparam int unsigned CW = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_READY    = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [LANES-1:0][RADIX-1:0]   lane_q, lane_d;
  logic                          seeded_q, seeded_d;
  logic                          advance;
  logic [RADIX-1:0]              seed_slice;

  // One xorshift step; bits shifted past either end are simply lost.
  function automatic logic [RADIX-1:0] step_f(input logic [RADIX-1:0] x);
    logic [RADIX-1:0] y;
    logic [RADIX-1:0] z;
    y = x ^ (x << SH_A);
    z = y ^ (y >> SH_B);
    return z ^ (z << SH_C);
  endfunction

  // Next-state logic: warm-up stepping, handshake stepping, seed override.
  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    seeded_d   = seeded_q;
    advance    = 1'b0;
    seed_slice = '0;

    case (state_q)
      ST_WARMUP: begin
        advance = 1'b1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_READY;
      end
      ST_READY: begin
        // rnd_valid is 1 here, so rnd_ready alone completes the handshake.
        advance = rnd_ready;
      end
      ST_UNSEEDED: ;
      default: state_d = ST_UNSEEDED;
    endcase

    if (advance) begin
      for (int i = 0; i < int'(LANES); i++) lane_d[i] = step_f(lane_q[i]);
    end

    // A seed load wins over any step; a same-cycle handshake has already
    // taken the word on rnd_out, so nothing is lost.
    if (seed_we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        seed_slice = seed[i*RADIX +: RADIX];
        // Zero is a fixed point of the step, so give each lane a distinct
        // nonzero replacement.
        lane_d[i]  = (seed_slice == '0) ? RADIX'(i + 1) : seed_slice;
      end
      cnt_d    = CW'(WARMUP);
      state_d  = ST_WARMUP;
      seeded_d = 1'b1;
    end
  end

  // State registers; lanes are cleared on reset because rnd_out must read 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_UNSEEDED;
      cnt_q    <= '0;
      lane_q   <= '0;
      seeded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      seeded_q <= seeded_d;
    end
  end

  assign rnd_valid = (state_q == ST_READY);
  assign rnd_out   = lane_q;
  assign seeded    = seeded_q;

endmodule

// File: tb/tb_xorshift_prng_multi.sv
// Self-checking bench for xorshift_prng_multi: a default-parameter instance
// and a WARMUP=1 instance share stimulus; a behavioural model supplies every
// expected value.
module tb_xorshift_prng_multi;

  localparam int RADIX  = 64;
  localparam int LANES  = 2;
  localparam int WARMUP = 4;
  localparam int W      = LANES * RADIX;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         seed_we = 1'b0;
  logic         rnd_ready = 1'b0;
  logic [W-1:0] seed = '0;

  logic         rnd_valid, seeded;
  logic [W-1:0] rnd_out;
  logic         rnd_valid_w1, seeded_w1;
  logic [W-1:0] rnd_out_w1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xorshift_prng_multi dut (
    .clk(clk), .rst_n(rst_n), .seed_we(seed_we), .seed(seed),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_out(rnd_out),
    .seeded(seeded)
  );

  xorshift_prng_multi #(.WARMUP(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .seed_we(seed_we), .seed(seed),
    .rnd_valid(rnd_valid_w1), .rnd_ready(rnd_ready), .rnd_out(rnd_out_w1),
    .seeded(seeded_w1)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] f(input logic [63:0] x);
    logic [63:0] y, z;
    y = x ^ (x << 21);
    z = y ^ (y >> 35);
    return z ^ (z << 4);
  endfunction

  // Value every lane should show after a seed load plus `steps` steps.
  function automatic logic [W-1:0] golden(input logic [W-1:0] s, input int steps);
    logic [W-1:0] r;
    logic [63:0]  x;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x = s[i*RADIX +: RADIX];
      if (x == 64'd0) x = 64'(i + 1);
      for (int k = 0; k < steps; k++) x = f(x);
      r[i*RADIX +: RADIX] = x;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] advance(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*RADIX +: RADIX] = f(v[i*RADIX +: RADIX]);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_seed();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [W-1:0] s);
    seed    = s;
    seed_we = 1'b1;
    tick();
    seed_we = 1'b0;
  endtask

  // Counts cycles (starting just after a seed edge) until rnd_valid rises.
  task automatic wait_valid(output int n);
    n = 0;
    while (rnd_valid !== 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  typedef struct {
    logic [W-1:0] seed;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[6];
  logic [W-1:0] exp_word;
  logic [W-1:0] new_seed;
  int           n;
  logic         take;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // WARMUP=1 vectors, lanes packed {lane1, lane0}.
    vecs[0] = '{seed: {64'h0, 64'h1},
                exp:  {64'h0000_0000_0440_0022, 64'h0000_0000_0220_0011}};
    vecs[1] = '{seed: {64'h0, 64'h0},
                exp:  {64'h0000_0000_0440_0022, 64'h0000_0000_0220_0011}};
    vecs[2] = '{seed: {64'h2, 64'h8000_0000_0000_0000},
                exp:  {64'h0000_0000_0440_0022, 64'h8000_0001_1000_0000}};
    vecs[3] = '{seed: {64'h8000_0000_0000_0000, 64'h0},
                exp:  {64'h8000_0001_1000_0000, 64'h0000_0000_0220_0011}};
    for (int i = 4; i < 6; i++) begin
      vecs[i].seed = rand_seed();
      vecs[i].exp  = golden(vecs[i].seed, 1);
    end

    // ---- reset state, and nothing happens without a seed ----
    rnd_ready = 1'b1;
    #12;
    check("reset_valid", W'(rnd_valid), W'(0));
    check("reset_out", rnd_out, '0);
    check("reset_seeded", W'(seeded), W'(0));
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_valid", W'(rnd_valid), W'(0));
      check("idle_out", rnd_out, '0);
      check("idle_seeded", W'(seeded), W'(0));
    end

    // ---- WARMUP=1 vector table ----
    rnd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_seed(vecs[i].seed);
      check($sformatf("w1_warm_valid[%0d]", i), W'(rnd_valid_w1), W'(0));
      check($sformatf("w1_seeded[%0d]", i), W'(seeded_w1), W'(1));
      tick();
      check($sformatf("w1_ready_valid[%0d]", i), W'(rnd_valid_w1), W'(1));
      check($sformatf("w1_out[%0d]", i), rnd_out_w1, vecs[i].exp);
    end

    // ---- default params: stall, then streaming ----
    new_seed = rand_seed();
    load_seed(new_seed);
    exp_word = golden(new_seed, WARMUP);
    wait_valid(n);
    check("warmup_len", W'(n), W'(WARMUP));
    check("first_word", rnd_out, exp_word);
    rnd_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_out", rnd_out, exp_word);
      check("stall_valid", W'(rnd_valid), W'(1));
    end
    rnd_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      exp_word = advance(exp_word);
      check("stream_out", rnd_out, exp_word);
      check("stream_valid", W'(rnd_valid), W'(1));
    end

    // ---- random ready pattern ----
    for (int c = 0; c < 200; c++) begin
      rnd_ready = 1'($urandom_range(0, 1));
      take = rnd_ready;
      tick();
      if (take) exp_word = advance(exp_word);
      check("rand_out", rnd_out, exp_word);
    end

    // ---- reseed in READY with a same-cycle handshake ----
    rnd_ready = 1'b1;
    check("hs_valid_before", W'(rnd_valid), W'(1));
    check("hs_word_taken", rnd_out, exp_word);
    new_seed = {rand_seed()};
    load_seed(new_seed);
    wait_valid(n);
    check("reseed_warmup_len", W'(n), W'(WARMUP));
    check("reseed_out", rnd_out, golden(new_seed, WARMUP));

    // ---- reseed with warm-up counter at 2 (second seed has a zero lane) ----
    rnd_ready = 1'b0;
    load_seed(rand_seed());
    tick();
    tick();
    check("mid_warm_valid", W'(rnd_valid), W'(0));
    new_seed = {64'h0, rand_seed()};
    new_seed[RADIX +: RADIX] = 64'h0;
    load_seed(new_seed);
    wait_valid(n);
    check("restart_warmup_len", W'(n), W'(WARMUP));
    check("restart_out", rnd_out, golden(new_seed, WARMUP));

    // ---- asynchronous reset mid-stream ----
    rnd_ready = 1'b1;
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", W'(rnd_valid), W'(0));
    check("async_rst_out", rnd_out, '0);
    check("async_rst_seeded", W'(seeded), W'(0));
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("post_rst_valid", W'(rnd_valid), W'(0));
      check("post_rst_out", rnd_out, '0);
    end
    new_seed = rand_seed();
    load_seed(new_seed);
    check("post_rst_seeded", W'(seeded), W'(1));
    wait_valid(n);
    check("post_rst_warmup_len", W'(n), W'(WARMUP));
    check("post_rst_out", rnd_out, golden(new_seed, WARMUP));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
